ps2_scan_receiver: RTL and testbench



---
 rtl/ps2_scan_receiver_if.sv | 21 ++
 rtl/ps2_scan_receiver.sv | 169 ++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_receiver_if.sv
// Bundle of PS/2 line inputs and decoded scan-code outputs for ps2_scan_receiver.
// The slave modport is the receiver side; the master modport is the keyboard/consumer side.
interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] Cambio;
    logic       got_data;
    logic       extended;
    logic       key_released;
    logic       frame_err;

    modport slave (
        input  ps2_clk, ps2_data,
        output Cambio, got_data, extended, key_released, frame_err
    );

    modport master (
        output ps2_clk, ps2_data,
        input  Cambio, got_data, extended, key_released, frame_err
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding into one make-code strobe per press.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_scan_receiver #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 100000,
    parameter int TW      = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_scan_receiver_if.slave   bus
);
    localparam int FW = $clog2(FILTER + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_filt, r_filt_d;
    logic [FW-1:0]   r_fcnt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shreg;
    logic [TW-1:0]   r_tcnt;
    logic            w_fe, w_frame_ok, w_frame_bad, w_par_ok;
    logic            r_vld_p0, r_err_p0;
    logic [7:0]      r_byte_p0;
    logic [7:0]      r_cambio_p1;
    logic            r_got_p1, r_ext_p1, r_rel_p1;
    logic            r_ext_pend, r_brk_pend;

    // Input conditioning: synchronizers and ps2_clk glitch filter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FW'(FILTER - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fe = r_filt_d & ~r_filt;

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    always_ff @(posedge clk) begin
        if (w_fe && r_state == S_PARITY)
            r_parity <= r_dat_s2;
    end
    assign w_par_ok = ^{r_parity, r_shreg};
`else
    assign w_par_ok = 1'b1;
`endif

    // Frame FSM
    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            S_IDLE:   if (w_fe && !r_dat_s2) w_state_nxt = S_DATA;
            S_DATA:   if (w_fe && r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_fe) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_fe) begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && w_par_ok) w_frame_ok  = 1'b1;
                    else                      w_frame_bad = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (r_state != S_IDLE && !w_fe && r_tcnt == TW'(TIMEOUT)) begin
            w_state_nxt = S_IDLE;
            w_frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fe && r_state == S_IDLE) r_bitcnt <= '0;
            else if (w_fe && r_state == S_DATA) r_bitcnt <= r_bitcnt + 1'b1;
            if (w_fe || r_state == S_IDLE) r_tcnt <= '0;
            else                           r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fe && r_state == S_DATA)
            r_shreg <= {r_dat_s2, r_shreg[7:1]};
    end

    // Stage p0: frame result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_err_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_frame_ok;
            r_err_p0 <= w_frame_bad;
        end
    end

    always_ff @(posedge clk) begin
        r_byte_p0 <= r_shreg;
    end

    // Stage p1: prefix decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cambio_p1 <= 8'h00;
            r_got_p1    <= 1'b0;
            r_ext_p1    <= 1'b0;
            r_rel_p1    <= 1'b0;
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
        end else begin
            r_got_p1 <= 1'b0;
            r_rel_p1 <= 1'b0;
            if (r_err_p0) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (r_vld_p0) begin
                if (r_byte_p0 == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_byte_p0 == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else if (r_brk_pend) begin
                    r_rel_p1   <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end else begin
                    r_cambio_p1 <= r_byte_p0;
                    r_got_p1    <= 1'b1;
                    r_ext_p1    <= r_ext_pend;
                    r_ext_pend  <= 1'b0;
                end
            end
        end
    end

    assign bus.Cambio       = r_cambio_p1;
    assign bus.got_data     = r_got_p1;
    assign bus.extended     = r_ext_p1;
    assign bus.key_released = r_rel_p1;
    assign bus.frame_err    = r_err_p0;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed table-driven bench for ps2_scan_receiver plus hand-written reset, timeout and glitch sequences.
module tb_ps2_scan_receiver;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 300;
    localparam int TW      = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_scan_receiver_if bus();

    ps2_scan_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_got = 0, n_rel = 0, n_err = 0, n_wide = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_ext = 1'b0;
    int         got_cyc = 0;
    int         fall_cyc = 0;
    logic       p_got = 1'b0, p_rel = 1'b0, p_err = 1'b0;

    always @(negedge clk) begin
        if (bus.got_data) begin
            n_got++;
            last_code = bus.Cambio;
            last_ext  = bus.extended;
            got_cyc   = cyc;
        end
        if (bus.key_released) n_rel++;
        if (bus.frame_err)    n_err++;
        if ((bus.got_data && p_got) || (bus.key_released && p_rel) || (bus.frame_err && p_err))
            n_wide++;
        p_got = bus.got_data;
        p_rel = bus.key_released;
        p_err = bus.frame_err;
    end

    typedef struct {
        logic [7:0] code;
        logic       stop;
        logic       pflip;
        int         d_got;
        int         d_rel;
        int         d_err;
        logic [7:0] exp_cambio;
        logic       exp_ext;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        bus.ps2_data = b;
        if (glitch) begin
            wait_cyc(4);
            bus.ps2_clk = 1'b0;
            wait_cyc(2);
            bus.ps2_clk = 1'b1;
            wait_cyc(4);
        end else begin
            wait_cyc(10);
        end
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(20);
        bus.ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic stop, input logic pflip,
                              input logic glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
        send_bit((~^code) ^ pflip, glitch);
        send_bit(stop, glitch);
        bus.ps2_data = 1'b1;
        wait_cyc(20);
    endtask

    int g0, r0, e0;

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;

        tbl[0]  = '{8'h73, 1'b1, 1'b0, 1, 0, 0, 8'h73, 1'b0};
        tbl[1]  = '{8'hF0, 1'b1, 1'b0, 0, 0, 0, 8'h73, 1'b0};
        tbl[2]  = '{8'h73, 1'b1, 1'b0, 0, 1, 0, 8'h73, 1'b0};
        tbl[3]  = '{8'hE0, 1'b1, 1'b0, 0, 0, 0, 8'h73, 1'b0};
        tbl[4]  = '{8'h72, 1'b1, 1'b0, 1, 0, 0, 8'h72, 1'b1};
        tbl[5]  = '{8'h73, 1'b1, 1'b0, 1, 0, 0, 8'h73, 1'b0};
        tbl[6]  = '{8'h72, 1'b0, 1'b0, 0, 0, 1, 8'h73, 1'b0};
        tbl[7]  = '{8'h72, 1'b1, 1'b0, 1, 0, 0, 8'h72, 1'b0};
        tbl[8]  = '{8'h72, 1'b1, 1'b0, 1, 0, 0, 8'h72, 1'b0};
        tbl[9]  = '{8'hE0, 1'b1, 1'b0, 0, 0, 0, 8'h72, 1'b0};
        tbl[10] = '{8'h73, 1'b0, 1'b0, 0, 0, 1, 8'h72, 1'b0};
        tbl[11] = '{8'h73, 1'b1, 1'b0, 1, 0, 0, 8'h73, 1'b0};
        tbl[12] = '{8'hF0, 1'b1, 1'b0, 0, 0, 0, 8'h73, 1'b0};
        tbl[13] = '{8'h72, 1'b0, 1'b0, 0, 0, 1, 8'h73, 1'b0};
        tbl[14] = '{8'h72, 1'b1, 1'b0, 1, 0, 0, 8'h72, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        tbl[15] = '{8'h73, 1'b1, 1'b1, 0, 0, 1, 8'h72, 1'b0};
`else
        tbl[15] = '{8'h73, 1'b1, 1'b1, 1, 0, 0, 8'h73, 1'b0};
`endif

        wait_cyc(3);
        chk("reset_cambio",   32'(bus.Cambio), 32'h00);
        chk("reset_got",      32'(bus.got_data), 0);
        chk("reset_extended", 32'(bus.extended), 0);
        chk("reset_released", 32'(bus.key_released), 0);
        chk("reset_frame_err", 32'(bus.frame_err), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Reset held mid-frame after 4 data bits, then a clean 73
        g0 = n_got; r0 = n_rel; e0 = n_err;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        bus.ps2_data = 1'b1;
        wait_cyc(30);
        chk("midrst_no_strobe", 32'((n_got - g0) + (n_rel - r0) + (n_err - e0)), 0);
        send_frame(8'h73, 1'b1, 1'b0, 1'b0);
        chk("midrst_got_count", 32'(n_got - g0), 1);
        chk("midrst_code",      32'(last_code), 32'h73);
        chk("midrst_ext",       32'(last_ext), 0);
        chk("latency",          32'(got_cyc - fall_cyc), 32'(FILTER + 4));
        chk("midrst_no_err",    32'(n_err - e0), 0);

        for (int v = 0; v < 16; v++) begin
            g0 = n_got; r0 = n_rel; e0 = n_err;
            send_frame(tbl[v].code, tbl[v].stop, tbl[v].pflip, 1'b0);
            chk($sformatf("v%0d_got", v), 32'(n_got - g0), 32'(tbl[v].d_got));
            chk($sformatf("v%0d_rel", v), 32'(n_rel - r0), 32'(tbl[v].d_rel));
            chk($sformatf("v%0d_err", v), 32'(n_err - e0), 32'(tbl[v].d_err));
            chk($sformatf("v%0d_cambio", v), 32'(bus.Cambio), 32'(tbl[v].exp_cambio));
            if (tbl[v].d_got != 0)
                chk($sformatf("v%0d_ext", v), 32'(last_ext), 32'(tbl[v].exp_ext));
        end

        // Frame stalled after 5 bits until the timeout aborts it
        g0 = n_got; e0 = n_err;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        bus.ps2_data = 1'b1;
        wait_cyc(TIMEOUT + 10);
        chk("timeout_err", 32'(n_err - e0), 1);
        chk("timeout_no_got", 32'(n_got - g0), 0);
        send_frame(8'h73, 1'b1, 1'b0, 1'b0);
        chk("after_timeout_got", 32'(n_got - g0), 1);
        chk("after_timeout_code", 32'(last_code), 32'h73);

        // Short ps2_clk glitches inside every bit of a frame
        g0 = n_got; e0 = n_err;
        send_frame(8'h72, 1'b1, 1'b0, 1'b1);
        chk("glitch_got", 32'(n_got - g0), 1);
        chk("glitch_code", 32'(last_code), 32'h72);
        chk("glitch_no_err", 32'(n_err - e0), 0);

        chk("strobe_width", 32'(n_wide), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
